// File: rtl/muldiv_unit_pkg.sv
// Shared types for the iterative multiply/divide unit: operation encoding
// and the mapping from MIPS-style funct codes.
package muldiv_unit_pkg;

    typedef enum logic [1:0] {
        MULT  = 2'd0,
        MULTU = 2'd1,
        DIV   = 2'd2,
        DIVU  = 2'd3
    } muldiv_op_t;

    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    function automatic muldiv_op_t funct_to_muldiv_op(input logic [5:0] funct);
        case (funct)
            FUNCT_MULTU: return MULTU;
            FUNCT_DIV:   return DIV;
            FUNCT_DIVU:  return DIVU;
            default:     return MULT;
        endcase
    endfunction

    function automatic logic op_is_signed(input muldiv_op_t op);
        return (op == MULT) || (op == DIV);
    endfunction

    function automatic logic op_is_div(input muldiv_op_t op);
        return (op == DIV) || (op == DIVU);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the execute stage and the mul/div unit.
`ifndef MULDIV_IF_SV
`define MULDIV_IF_SV

interface muldiv_if #(parameter int WIDTH = 32);
    import muldiv_unit_pkg::*;

    logic             start;
    muldiv_op_t       op;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             flush;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdat;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport md (
        input  start, op, opa, opb, flush, hi_we, lo_we, wdat,
        output busy, done, div_zero, hi, lo
    );

    modport tb (
        output start, op, opa, opb, flush, hi_we, lo_we, wdat,
        input  busy, done, div_zero, hi, lo
    );

endinterface

`endif

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit owning HI/LO; one op at a time,
// WIDTH+1 busy cycles per op (WIDTH steps in CALC, one commit cycle in FIX).
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic CLK,
    input  logic RST,
    muldiv_if.md bus
);

    // state | meaning
    // IDLE  | accepts start and direct HI/LO writes
    // CALC  | one shift-add / restoring-divide step per cycle
    // FIX   | apply signs, commit HI/LO, pulse done
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    localparam int CW = $clog2(WIDTH);

    state_t             r_state;
    state_t             w_state_nxt;
    muldiv_op_t         r_op;
    logic               r_sign_a;
    logic               r_sign_b;
    logic               r_dz;
    logic               r_done;
    logic               r_div_zero;
    logic [CW-1:0]      r_count;
    logic [WIDTH-1:0]   r_opa;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [2*WIDTH-1:0] r_acc;

    logic               w_start_ok;
    logic               w_sign_a;
    logic               w_sign_b;
    logic               w_neg;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_step;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_rem_sub;
    logic               w_ge;
    logic [2*WIDTH-1:0] w_div_step;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;

    // Conditional two's-complement negate; cin chains the carry between halves.
    function automatic logic [WIDTH-1:0] neg_w(input logic neg, input logic [WIDTH-1:0] x,
                                               input logic cin);
        return neg ? (~x + {{(WIDTH-1){1'b0}}, cin}) : x;
    endfunction

    assign w_start_ok = (r_state == IDLE) && bus.start && !bus.flush;
    assign w_sign_a   = op_is_signed(bus.op) && bus.opa[WIDTH-1];
    assign w_sign_b   = op_is_signed(bus.op) && bus.opb[WIDTH-1];
    assign w_neg      = r_sign_a ^ r_sign_b;

    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_b : {WIDTH{1'b0}})};
    assign w_mul_step = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Partial remainder stays below the divisor, so the borrow bit is the compare result.
    assign w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_rem_sub  = w_rem_sh - {1'b0, r_b};
    assign w_ge       = ~w_rem_sub[WIDTH];
    assign w_div_step = {(w_ge ? w_rem_sub[WIDTH-1:0] : w_rem_sh[WIDTH-1:0]),
                         r_acc[WIDTH-2:0], w_ge};

    always_comb begin
        w_res_lo = neg_w(w_neg, r_acc[WIDTH-1:0], 1'b1);
        w_res_hi = neg_w(w_neg, r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1:0] == '0);
        if (r_dz) begin
            w_res_hi = r_opa;
            w_res_lo = '1;
        end else if (op_is_div(r_op)) begin
            w_res_hi = neg_w(r_sign_a, r_acc[2*WIDTH-1:WIDTH], 1'b1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start_ok) w_state_nxt = CALC;
            CALC: begin
                if (bus.flush)           w_state_nxt = IDLE;
                else if (r_count == '0)  w_state_nxt = FIX;
            end
            FIX:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_op       <= MULT;
            r_sign_a   <= 1'b0;
            r_sign_b   <= 1'b0;
            r_dz       <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            r_count    <= '0;
            r_opa      <= '0;
            r_b        <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_acc      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.hi_we) r_hi <= bus.wdat;
                    if (bus.lo_we) r_lo <= bus.wdat;
                    if (w_start_ok) begin
                        r_op       <= bus.op;
                        r_sign_a   <= w_sign_a;
                        r_sign_b   <= w_sign_b;
                        r_opa      <= bus.opa;
                        r_b        <= neg_w(w_sign_b, bus.opb, 1'b1);
                        r_acc      <= {{WIDTH{1'b0}}, neg_w(w_sign_a, bus.opa, 1'b1)};
                        r_count    <= CW'(WIDTH - 1);
                        r_dz       <= op_is_div(bus.op) && (bus.opb == '0);
                        r_div_zero <= 1'b0;
                    end
                end
                CALC: begin
                    r_acc   <= op_is_div(r_op) ? w_div_step : w_mul_step;
                    r_count <= r_count - CW'(1);
                end
                FIX: begin
                    if (!bus.flush) begin
                        r_hi       <= w_res_hi;
                        r_lo       <= w_res_lo;
                        r_div_zero <= r_dz;
                        r_done     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = (r_state != IDLE);
    assign bus.done     = r_done;
    assign bus.div_zero = r_div_zero;
    assign bus.hi       = r_hi;
    assign bus.lo       = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed + randomized bench for muldiv_unit against a 64-bit arithmetic reference.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    localparam int W = 32;

    logic CLK = 1'b0;
    logic RST;
    int   n_total = 0;
    int   n_pass  = 0;

    muldiv_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reference: plain signed/unsigned 64-bit arithmetic, truncating division.
    function automatic void ref_model(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] ehi, output logic [31:0] elo,
                                      output logic edz);
        longint      sa, sb, p, q, r;
        logic [63:0] u, ur;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        edz = 1'b0;
        ehi = '0;
        elo = '0;
        if ((op == DIV || op == DIVU) && b == 32'd0) begin
            edz = 1'b1;
            ehi = a;
            elo = 32'hFFFF_FFFF;
        end else begin
            case (op)
                MULT: begin
                    p = sa * sb;
                    ehi = p[63:32]; elo = p[31:0];
                end
                MULTU: begin
                    u = {32'h0, a} * {32'h0, b};
                    ehi = u[63:32]; elo = u[31:0];
                end
                DIV: begin
                    q = sa / sb; r = sa % sb;
                    ehi = r[31:0]; elo = q[31:0];
                end
                default: begin
                    u = {32'h0, a} / {32'h0, b}; ur = {32'h0, a} % {32'h0, b};
                    ehi = ur[31:0]; elo = u[31:0];
                end
            endcase
        end
    endfunction

    // Called right after a negedge; returns on the negedge where done is seen.
    task automatic run_op(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b,
                          input string tag, input bit wr_lo = 1'b0, input logic [31:0] wd = '0);
        logic [31:0] ehi, elo;
        logic        edz;
        int          busy_n, done_at;
        ref_model(op, a, b, ehi, elo, edz);
        bus.start = 1'b1; bus.op = op; bus.opa = a; bus.opb = b;
        bus.lo_we = wr_lo; bus.wdat = wd;
        busy_n = 0; done_at = -1;
        for (int j = 0; j < 40 && done_at < 0; j++) begin
            @(negedge CLK);
            if (j == 0) begin
                bus.start = 1'b0; bus.lo_we = 1'b0;
                check({tag, ":done_first"}, 64'(bus.done), 64'd0);
                check({tag, ":dz_cleared"}, 64'(bus.div_zero), 64'd0);
                if (wr_lo) check({tag, ":lo_we_now"}, 64'(bus.lo), 64'(wd));
            end
            if (wr_lo && j == 20) check({tag, ":lo_we_held"}, 64'(bus.lo), 64'(wd));
            if (bus.done) done_at = j;
            else if (bus.busy) busy_n++;
        end
        check({tag, ":done_cycle"}, 64'(done_at), 64'd33);
        check({tag, ":busy_cycles"}, 64'(busy_n), 64'd33);
        check({tag, ":busy_at_done"}, 64'(bus.busy), 64'd0);
        check({tag, ":hi"}, 64'(bus.hi), 64'(ehi));
        check({tag, ":lo"}, 64'(bus.lo), 64'(elo));
        check({tag, ":div_zero"}, 64'(bus.div_zero), 64'(edz));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b, prev_hi;
        int          n_done, n_busy;
        muldiv_op_t  rop;

        RST = 1'b1;
        bus.start = 1'b0; bus.op = MULT; bus.opa = '0; bus.opb = '0;
        bus.flush = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdat = '0;
        @(negedge CLK);
        check("rst:hi", 64'(bus.hi), 64'd0);
        check("rst:lo", 64'(bus.lo), 64'd0);
        check("rst:done", 64'(bus.done), 64'd0);
        check("rst:div_zero", 64'(bus.div_zero), 64'd0);
        check("rst:busy", 64'(bus.busy), 64'd0);
        RST = 1'b0;
        @(negedge CLK);

        run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        check("multu_max:hi_const", 64'(bus.hi), 64'h0000_0000_FFFF_FFFE);
        check("multu_max:lo_const", 64'(bus.lo), 64'h0000_0000_0000_0001);

        run_op(MULT, 32'hFFFF_FFFD, 32'd7, "mult_neg");
        check("mult_neg:lo_const", 64'(bus.lo), 64'h0000_0000_FFFF_FFEB);
        run_op(DIV, 32'hFFFF_FFF9, 32'd2, "div_b2b");
        check("div_b2b:lo_const", 64'(bus.lo), 64'h0000_0000_FFFF_FFFD);
        check("div_b2b:hi_const", 64'(bus.hi), 64'h0000_0000_FFFF_FFFF);

        run_op(DIVU, 32'd5, 32'd0, "divu_zero");
        run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1");
        check("div_min_m1:lo_const", 64'(bus.lo), 64'h0000_0000_8000_0000);

        // Preload, then flush a MULT at cycle 10 with an ignored start pulse inside.
        bus.hi_we = 1'b1; bus.wdat = 32'hA5A5_A5A5;
        @(negedge CLK);
        bus.hi_we = 1'b0; bus.lo_we = 1'b1; bus.wdat = 32'h5A5A_5A5A;
        check("mthi:hi", 64'(bus.hi), 64'h0000_0000_A5A5_A5A5);
        @(negedge CLK);
        bus.lo_we = 1'b0;
        check("mtlo:lo", 64'(bus.lo), 64'h0000_0000_5A5A_5A5A);
        bus.start = 1'b1; bus.op = MULT; bus.opa = $urandom; bus.opb = $urandom;
        for (int j = 0; j < 10; j++) begin
            @(negedge CLK);
            bus.start = (j == 4);
            bus.op = DIVU;
            if (j == 9) bus.flush = 1'b1;
        end
        @(negedge CLK);
        bus.flush = 1'b0;
        check("flush:busy", 64'(bus.busy), 64'd0);
        check("flush:hi", 64'(bus.hi), 64'h0000_0000_A5A5_A5A5);
        check("flush:lo", 64'(bus.lo), 64'h0000_0000_5A5A_5A5A);
        n_done = 0; n_busy = 0;
        for (int j = 0; j < 40; j++) begin
            @(negedge CLK);
            if (bus.done) n_done++;
            if (bus.busy) n_busy++;
        end
        check("flush:no_done", 64'(n_done), 64'd0);
        check("flush:stays_idle", 64'(n_busy), 64'd0);

        bus.start = 1'b1; bus.flush = 1'b1; bus.op = MULTU;
        @(negedge CLK);
        bus.start = 1'b0; bus.flush = 1'b0;
        check("flush_start:dropped", 64'(bus.busy), 64'd0);

        // hi_we while busy is ignored; RST mid-DIV clears everything asynchronously.
        bus.start = 1'b1; bus.op = DIV; bus.opa = $urandom; bus.opb = $urandom | 32'd1;
        prev_hi = bus.hi;
        for (int j = 0; j < 15; j++) begin
            @(negedge CLK);
            bus.start = 1'b0;
            bus.hi_we = (j == 3);
            bus.wdat  = 32'hDEAD_BEEF;
            if (j == 4) check("busy_mthi:hi", 64'(bus.hi), 64'(prev_hi));
        end
        bus.hi_we = 1'b0;
        RST = 1'b1;
        #1;
        check("rst_mid:busy", 64'(bus.busy), 64'd0);
        check("rst_mid:hi", 64'(bus.hi), 64'd0);
        check("rst_mid:lo", 64'(bus.lo), 64'd0);
        check("rst_mid:done", 64'(bus.done), 64'd0);
        check("rst_mid:div_zero", 64'(bus.div_zero), 64'd0);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);

        run_op(MULTU, $urandom, $urandom, "start_lo_we", 1'b1, 32'h1234_5678);

        for (int k = 0; k < 10; k++) begin
            rop = muldiv_op_t'($urandom_range(0, 3));
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 20);
                2:       b = -$urandom_range(1, 20);
                default: b = $urandom;
            endcase
            run_op(rop, a, b, $sformatf("rand%0d", k));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit that runs beside the single-cycle ALU in the execute stage and owns the architectural HI/LO registers. It accepts one signed or unsigned MULT/DIV operation at a time through a start/busy/done handshake. It computes the result over WIDTH+1 cycles and commits it to HI/LO. It also services direct HI/LO writes (MTHI/MTLO) and a pipeline flush.

## Interface
Parameters:
- WIDTH, 32, operand, HI and LO width; any value ≥ 4.

Ports (bundled in interface muldiv_if, modports md and tb):
- CLK  in  1  clock, all state updates on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- op  in  2  muldiv_op_t: MULT, MULTU, DIV, DIVU.
- opa  in  WIDTH  multiplicand / dividend; sampled with start.
- opb  in  WIDTH  multiplier / divisor; sampled with start.
- flush  in  1  abort the in-flight operation.
- hi_we  in  1  write HI from wdat (MTHI).
- lo_we  in  1  write LO from wdat (MTLO).
- wdat  in  WIDTH  direct write data.
- busy  out  1  high whenever state ≠ IDLE (combinational from state).
- done  out  1  one-cycle pulse when HI/LO are committed.
- div_zero  out  1  registered; valid with done; cleared on the next accepted start.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation
- Reset values: state IDLE, hi = 0, lo = 0, done = 0, div_zero = 0, busy = 0. RST mid-operation aborts immediately and no done is produced.
- States:
  - IDLE: start=1 latches op, operands and sign bits, stores magnitudes (|x| for signed ops, raw for unsigned), loads count = WIDTH−1, then goes to CALC.
  - CALC: one radix-2 step per cycle. count==0 goes to FIX.
  - FIX: apply signs, write hi/lo, assert done for one cycle, go to IDLE.
- Multiply: shift-add over a 2·WIDTH accumulator. Negate the product if sign(a) xor sign(b) (signed op only). hi = upper WIDTH bits, lo = lower WIDTH bits.
- Divide: restoring division on magnitudes.
  - Quotient goes to lo and is negated if the signs differ.
  - Remainder goes to hi and takes the dividend's sign.
  - Signed MIN / −1: lo = MIN, hi = 0 (wraps, no trap).
- Divide by zero (opb == 0): hi = opa, lo = all ones, div_zero = 1 with done. Signedness is ignored for this case.
- start while busy: ignored. The issuing stage stalls on busy.
- flush: in CALC/FIX, go to IDLE next edge. hi/lo are unchanged and no done is produced. In IDLE with start=1, flush wins and the request is dropped.
- hi_we/lo_we: honoured only in IDLE and ignored while busy.
  - Same-cycle start + hi_we in IDLE: the write lands now, and the operation overwrites it at FIX.

## Timing
- Start accepted at edge E0.
- busy is high from E0 through the FIX edge (E0+WIDTH+1).
- hi, lo and done are visible after edge E0+WIDTH+1, i.e. WIDTH+1 cycles of busy; done is high for exactly one cycle.
- Back-to-back: start may be asserted in the cycle done is high. It is accepted on that edge because state is IDLE.
- Direct writes: hi/lo updated on the next edge, 1-cycle latency.
- No combinational path from inputs to outputs. busy depends only on state.

## Structure
- cpu_types_pkg: add muldiv_op_t (2-bit enum: MULT, MULTU, DIV, DIVU) and the mapping from funct codes.
- muldiv_if.vh: interface with modports md (unit) and tb (bench), guarded by ifndef like the other interface headers.
- State enum (IDLE, CALC, FIX) is local to the module.
- Single module. The sign-fix/negate logic is a local function, not a sub-module.

## Test plan
WIDTH = 32; done is expected 33 cycles after the start edge.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> hi = 0xFFFFFFFE, lo = 0x00000001, single done pulse at cycle 33, busy high cycles 1–33.
- MULT −3 × 7 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFEB. Then DIV −7 / 2 issued on the done cycle -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
- DIVU 5 / 0 -> hi = 0x00000005, lo = 0xFFFFFFFF, div_zero = 1. Next start clears div_zero. DIV 0x80000000 / −1 -> lo = 0x80000000, hi = 0.
- Flush at cycle 10 of a MULT, with hi/lo preloaded via hi_we/lo_we to 0xA5A5A5A5 / 0x5A5A5A5A -> busy low next cycle, no done, hi/lo unchanged. A start pulse mid-operation is ignored.
- RST asserted mid-DIV -> all outputs 0 asynchronously. hi_we while busy has no effect. Simultaneous start + lo_we in IDLE -> lo = wdat for the operation's duration, then the result.
